// File: rtl/w0rm_core_regfile_mp_if.sv
// Decode/ALU/writeback bundle for the W0RM register-fetch stage.
// master = surrounding pipeline, slave = the register-fetch stage.
interface w0rm_core_regfile_mp_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGISTERS   = 16,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int USER_WIDTH      = 64
);
  localparam int ADDR_BITS = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;

  logic                                  flush;
  logic                                  decode_valid;
  logic                                  decode_ready;
  logic [NUM_READ_PORTS*ADDR_BITS-1:0]   src_addr;
  logic [NUM_READ_PORTS-1:0]             src_used;
  logic [ADDR_BITS-1:0]                  dest_addr;
  logic                                  dest_used;
  logic [USER_WIDTH-1:0]                 user_data_in;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  operand_data;
  logic [ADDR_BITS-1:0]                  dest_addr_out;
  logic                                  dest_used_out;
  logic [USER_WIDTH-1:0]                 user_data_out;
  logic                                  rfetch_valid;
  logic                                  alu_ready;
  logic [NUM_WRITE_PORTS-1:0]            wr_enable;
  logic [NUM_WRITE_PORTS*ADDR_BITS-1:0]  wr_addr;
  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data;
  logic [NUM_REGISTERS-1:0]              pending;

  modport master (
    output flush, decode_valid, src_addr, src_used, dest_addr, dest_used, user_data_in,
           alu_ready, wr_enable, wr_addr, wr_data,
    input  decode_ready, operand_data, dest_addr_out, dest_used_out, user_data_out,
           rfetch_valid, pending
  );

  modport slave (
    input  flush, decode_valid, src_addr, src_used, dest_addr, dest_used, user_data_in,
           alu_ready, wr_enable, wr_addr, wr_data,
    output decode_ready, operand_data, dest_addr_out, dest_used_out, user_data_out,
           rfetch_valid, pending
  );
endinterface

// File: rtl/w0rm_core_regfile_mp.sv
// Scoreboarded register fetch: operands registered 1 cycle after accept; decode stalls on RAW/WAW hazards and ALU backpressure.
// Define W0RM_REGFILE_ZERO_REG_EN to hardwire r0 to zero (never written, never pending, never a hazard).
module w0rm_core_regfile_mp #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGISTERS   = 16,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int USER_WIDTH      = 64
) (
  input logic                   clk,
  input logic                   reset,
  w0rm_core_regfile_mp_if.slave bus
);
  localparam int ADDR_BITS = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
`ifdef W0RM_REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef logic [ADDR_BITS-1:0]  addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  data_t                               regs   [NUM_REGISTERS];
  data_t                               wr_fwd [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0]            wr_hit;
  logic [NUM_REGISTERS-1:0]            excluded;
  logic [NUM_REGISTERS-1:0]            blocked;
  logic [NUM_REGISTERS-1:0]            pend_q;
  logic [NUM_REGISTERS-1:0]            pend_d;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] ops_d;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] ops_q;
  addr_t                               dest_q;
  logic                                used_q;
  logic                                valid_q;
  logic [USER_WIDTH-1:0]               user_q;
  logic                                handoff;
  logic                                reserve;
  logic                                hazard;
  logic                                ready;
  logic                                accept;

  always_comb begin
    excluded    = '0;
    excluded[0] = ZERO_REG;
  end

  // Per-register view of this cycle's writeback; later ports override earlier ones.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      wr_fwd[r] = '0;
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (bus.wr_enable[p] && !excluded[r] &&
            bus.wr_addr[p*ADDR_BITS +: ADDR_BITS] == addr_t'(r)) begin
          wr_hit[r] = 1'b1;
          wr_fwd[r] = bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign handoff = valid_q && bus.alu_ready && !bus.flush;
  assign reserve = handoff && used_q && !excluded[dest_q];

  // A register is blocked while an older writer is outstanding: either already
  // scoreboarded and not written back now, or still parked in the output stage.
  always_comb begin
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      blocked[r] = !excluded[r] &&
                   ((pend_q[r] && !wr_hit[r]) ||
                    (valid_q && used_q && dest_q == addr_t'(r) && !handoff));
    end
  end

  always_comb begin
    hazard = bus.dest_used && blocked[bus.dest_addr];
    for (int k = 0; k < NUM_READ_PORTS; k++) begin
      if (bus.src_used[k] && blocked[bus.src_addr[k*ADDR_BITS +: ADDR_BITS]]) begin
        hazard = 1'b1;
      end
    end
  end

  assign ready  = !reset && !bus.flush && (!valid_q || bus.alu_ready) && !hazard;
  assign accept = bus.decode_valid && ready;

  always_comb begin
    ops_d = '0;
    for (int k = 0; k < NUM_READ_PORTS; k++) begin
      ops_d[k*DATA_WIDTH +: DATA_WIDTH] =
        wr_hit[bus.src_addr[k*ADDR_BITS +: ADDR_BITS]] ?
          wr_fwd[bus.src_addr[k*ADDR_BITS +: ADDR_BITS]] :
          regs[bus.src_addr[k*ADDR_BITS +: ADDR_BITS]];
    end
  end

  // Reservation beats a same-cycle release of the same register.
  always_comb begin
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      pend_d[r] = (reserve && dest_q == addr_t'(r)) || (pend_q[r] && !wr_hit[r]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGISTERS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGISTERS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_fwd[r];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ops_q   <= '0;
      dest_q  <= '0;
      used_q  <= 1'b0;
      user_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ops_q   <= ops_d;
      dest_q  <= bus.dest_addr;
      used_q  <= bus.dest_used;
      user_q  <= bus.user_data_in;
    end else if (bus.flush || (valid_q && bus.alu_ready)) begin
      valid_q <= 1'b0;
      ops_q   <= '0;
      dest_q  <= '0;
      used_q  <= 1'b0;
      user_q  <= '0;
    end
  end

  assign bus.decode_ready  = ready;
  assign bus.operand_data  = ops_q;
  assign bus.dest_addr_out = dest_q;
  assign bus.dest_used_out = used_q;
  assign bus.user_data_out = user_q;
  assign bus.rfetch_valid  = valid_q;
  assign bus.pending       = pend_q;
endmodule

// File: tb/tb_w0rm_core_regfile_mp.sv
// Bench for w0rm_core_regfile_mp: array/scoreboard model checked every cycle plus directed literal checks.
module tb_w0rm_core_regfile_mp;
  localparam int DW = 32, NR = 16, RP = 2, WP = 2, UW = 64, AB = 4;
`ifdef W0RM_REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  w0rm_core_regfile_mp_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_READ_PORTS(RP),
                            .NUM_WRITE_PORTS(WP), .USER_WIDTH(UW)) bus ();

  w0rm_core_regfile_mp #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_READ_PORTS(RP),
                         .NUM_WRITE_PORTS(WP), .USER_WIDTH(UW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0]    m_regs [NR];
  logic [NR-1:0]    m_pend;
  logic             m_valid, m_used;
  int               m_dest;
  logic [RP*DW-1:0] m_ops;
  logic [UW-1:0]    m_user;
  bit               mu_rdy, mu_hand, mu_ou;
  int               mu_od;

  function automatic bit zr(input int a);
    return ZR && (a == 0);
  endfunction

  function automatic int waddr(input int p);
    return int'(bus.wr_addr[p*AB +: AB]);
  endfunction

  function automatic int saddr(input int k);
    return int'(bus.src_addr[k*AB +: AB]);
  endfunction

  function automatic bit m_hit(input int a);
    for (int p = 0; p < WP; p++)
      if (bus.wr_enable[p] && waddr(p) == a && !zr(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    logic [DW-1:0] v;
    v = m_regs[a];
    for (int p = 0; p < WP; p++)
      if (bus.wr_enable[p] && waddr(p) == a && !zr(a)) v = bus.wr_data[p*DW +: DW];
    return v;
  endfunction

  function automatic bit m_busy(input int a);
    if (zr(a)) return 1'b0;
    return (m_pend[a] && !m_hit(a)) ||
           (m_valid && m_used && m_dest == a && !(bus.alu_ready && !bus.flush));
  endfunction

  function automatic bit m_ready();
    if (reset || bus.flush) return 1'b0;
    if (m_valid && !bus.alu_ready) return 1'b0;
    for (int k = 0; k < RP; k++)
      if (bus.src_used[k] && m_busy(saddr(k))) return 1'b0;
    if (bus.dest_used && m_busy(int'(bus.dest_addr))) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_pend = '0; m_valid = 1'b0; m_used = 1'b0; m_dest = 0; m_ops = '0; m_user = '0;
    end else begin
      mu_rdy  = m_ready();
      mu_hand = m_valid && bus.alu_ready && !bus.flush;
      mu_od   = m_dest;
      mu_ou   = m_used;
      for (int p = 0; p < WP; p++)
        if (bus.wr_enable[p] && !zr(waddr(p))) m_pend[waddr(p)] = 1'b0;
      if (mu_hand && mu_ou && !zr(mu_od)) m_pend[mu_od] = 1'b1;
      if (bus.decode_valid && mu_rdy) begin
        for (int k = 0; k < RP; k++) m_ops[k*DW +: DW] = m_read(saddr(k));
        m_dest = int'(bus.dest_addr); m_used = bus.dest_used; m_user = bus.user_data_in;
        m_valid = 1'b1;
      end else if (bus.flush || (m_valid && bus.alu_ready)) begin
        m_valid = 1'b0; m_used = 1'b0; m_dest = 0; m_ops = '0; m_user = '0;
      end
      for (int p = 0; p < WP; p++)
        if (bus.wr_enable[p] && !zr(waddr(p))) m_regs[waddr(p)] = bus.wr_data[p*DW +: DW];
    end
  end

  // Compare every cycle, mid-period.
  initial forever begin
    @(negedge clk);
    if (!reset && chk_en) begin
      chk("m_decode_ready", bus.decode_ready, m_ready());
      chk("m_rfetch_valid", bus.rfetch_valid, m_valid);
      chk("m_operand_data", bus.operand_data, m_ops);
      chk("m_dest_addr_out", bus.dest_addr_out, m_dest[AB-1:0]);
      chk("m_dest_used_out", bus.dest_used_out, m_used);
      chk("m_user_data_out", bus.user_data_out, m_user);
      chk("m_pending", bus.pending, m_pend);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.flush = 1'b0; bus.decode_valid = 1'b0; bus.src_addr = '0; bus.src_used = '0;
    bus.dest_addr = '0; bus.dest_used = 1'b0; bus.user_data_in = '0; bus.alu_ready = 1'b1;
    bus.wr_enable = '0; bus.wr_addr = '0; bus.wr_data = '0;
  endtask

  task automatic dec(input bit v, input logic [1:0] su, input int s0, input int s1,
                     input bit du, input int d, input logic [63:0] u);
    bus.decode_valid = v; bus.src_used = su;
    bus.src_addr = {4'(s1), 4'(s0)};
    bus.dest_used = du; bus.dest_addr = 4'(d); bus.user_data_in = u;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    bus.wr_enable[p] = 1'b1;
    bus.wr_addr[p*AB +: AB] = 4'(a);
    bus.wr_data[p*DW +: DW] = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #40000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1 reset = 1'b1;
    #2;
    chk("reset_ready", bus.decode_ready, 1'b0);
    chk("reset_valid", bus.rfetch_valid, 1'b0);
    chk("reset_pending", bus.pending, 16'h0);
    chk("reset_ops", bus.operand_data, 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", bus.decode_ready, 1'b1);

    // write collision: port 1 wins, and bypass sees it
    cyc(); idle(); wr(0, 5, 32'hAAAA); wr(1, 5, 32'h5555); dec(1, 2'b01, 5, 0, 0, 0, 64'hDEAD);
    @(negedge clk); chk("collision_ready", bus.decode_ready, 1'b1);
    cyc(); idle(); dec(1, 2'b11, 5, 5, 0, 0, 64'h1);
    @(negedge clk);
    chk("collision_bypass", bus.operand_data[31:0], 32'h5555);
    chk("collision_valid", bus.rfetch_valid, 1'b1);
    cyc(); idle();
    @(negedge clk); chk("collision_array", bus.operand_data, 64'h0000_5555_0000_5555);

    // RAW stall on R3, released by writeback with bypass
    cyc(); idle(); dec(1, 2'b00, 0, 0, 1, 3, 64'h3);
    cyc(); idle();
    @(negedge clk); chk("raw_stage_dest", bus.dest_addr_out, 4'd3);
    cyc(); idle(); dec(1, 2'b01, 3, 0, 0, 0, 64'h4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("raw_stall_ready", bus.decode_ready, 1'b0);
      chk("raw_pending", bus.pending, 16'h0008);
      cyc();
    end
    wr(0, 3, 32'h1234);
    @(negedge clk); chk("raw_wb_ready", bus.decode_ready, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("raw_bypass_op", bus.operand_data[31:0], 32'h1234);
    chk("raw_release", bus.pending, 16'h0);

    // set beats release on R7
    cyc(); idle(); dec(1, 2'b00, 0, 0, 1, 7, 64'h7); bus.alu_ready = 1'b0;
    cyc(); idle(); bus.alu_ready = 1'b0;
    @(negedge clk);
    chk("sbr_hold_valid", bus.rfetch_valid, 1'b1);
    chk("sbr_hold_dest", bus.dest_addr_out, 4'd7);
    cyc(); idle(); wr(1, 7, 32'h77);
    cyc(); idle();
    @(negedge clk); chk("sbr_pending", bus.pending, 16'h0080);
    wr(0, 7, 32'h78);
    cyc(); idle();
    @(negedge clk); chk("sbr_released", bus.pending, 16'h0);

    // flush drops the stage without reserving R2
    dec(1, 2'b00, 0, 0, 1, 2, 64'h2);
    cyc(); idle(); bus.alu_ready = 1'b0;
    @(negedge clk);
    chk("flush_pre_valid", bus.rfetch_valid, 1'b1);
    chk("flush_pre_dest", bus.dest_addr_out, 4'd2);
    cyc(); idle(); bus.flush = 1'b1; dec(1, 2'b00, 0, 0, 0, 0, 64'h9);
    @(negedge clk); chk("flush_ready", bus.decode_ready, 1'b0);
    cyc(); idle();
    @(negedge clk);
    chk("flush_valid", bus.rfetch_valid, 1'b0);
    chk("flush_pending", bus.pending, 16'h0);

    // back-to-back independent reads with bypass and array paths
    for (int i = 0; i < 8; i++) begin
      idle(); wr(0, 8 + i, 32'h1000 + 32'(i));
      dec(1, 2'b11, 8 + i, (i == 0) ? 8 : 7 + i, 0, 0, 64'(i));
      cyc();
    end
    idle();
    @(negedge clk);
    chk("tput_pin_ops", bus.operand_data, {32'h1006, 32'h1007});
    chk("tput_pin_user", bus.user_data_out, 64'h7);

    // mixed hazards, backpressure and writebacks
    for (int i = 0; i < 12; i++) begin
      idle(); bus.alu_ready = (i % 3) != 1;
      dec(1, 2'b01, 12 + (i % 2), 0, 1, 12 + ((i + 1) % 2), 64'(i));
      if (i >= 2) wr(1, 12 + (i % 2), 32'hC000 + 32'(i));
      cyc();
    end
    idle(); cyc(); cyc();
    wr(0, 12, 32'hC0); wr(1, 13, 32'hC1);
    cyc(); idle();
    @(negedge clk); chk("mix_drain_pending", bus.pending, 16'h0);

    // asynchronous reset during a stall
    dec(1, 2'b00, 0, 0, 1, 3, 64'h33);
    cyc(); idle(); dec(1, 2'b01, 5, 0, 0, 0, 64'h55);
    cyc(); idle(); bus.alu_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_pending", bus.pending, 16'h0008);
    chk("rst_pre_valid", bus.rfetch_valid, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_valid", bus.rfetch_valid, 1'b0);
    chk("rst_async_pending", bus.pending, 16'h0);
    chk("rst_async_ops", bus.operand_data, 64'h0);
    chk("rst_async_user", bus.user_data_out, 64'h0);
    chk("rst_async_ready", bus.decode_ready, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(); dec(1, 2'b11, 5, 3, 0, 0, 64'h0);
    @(negedge clk); chk("rst_post_ready", bus.decode_ready, 1'b1);
    cyc(); idle();
    @(negedge clk); chk("rst_post_array", bus.operand_data, 64'h0);

`ifdef W0RM_REGFILE_ZERO_REG_EN
    cyc(); idle(); wr(0, 0, 32'hFFFF_FFFF); dec(1, 2'b01, 0, 0, 0, 0, 64'h0);
    cyc(); idle();
    @(negedge clk); chk("zero_bypass", bus.operand_data[31:0], 32'h0);
    dec(1, 2'b00, 0, 0, 1, 0, 64'h0);
    cyc(); idle();
    cyc(); idle(); dec(1, 2'b01, 0, 0, 0, 0, 64'h0);
    @(negedge clk); chk("zero_no_stall", bus.decode_ready, 1'b1);
`endif

    cyc(); idle(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/w0rm_core_regfile_mp.md
# w0rm_core_regfile_mp

Multi-port, scoreboarded register-fetch stage for the W0RM core, sitting between decode and the ALU. It holds the architectural register array with a parametrised number of read and write ports. It tracks outstanding destination writes with a per-register pending bit and stalls decode on RAW/WAW hazards. It presents operands plus user/control data to the ALU through a registered valid/ready stage.

## Interface
- DATA_WIDTH, 32, register width
- NUM_REGISTERS, 16, register count; ADDR_BITS = ceil(log2(NUM_REGISTERS))
- NUM_READ_PORTS, 2, source operands per instruction (1..4)
- NUM_WRITE_PORTS, 2, writeback ports (1..4)
- USER_WIDTH, 64, opaque control payload carried alongside operands

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  drop the output-stage instruction
- decode_valid  in  1  decode offers an instruction
- decode_ready  out  1  stage accepts this cycle
- src_addr  in  NUM_READ_PORTS*ADDR_BITS  source addresses; port k at [k*ADDR_BITS +: ADDR_BITS]
- src_used  in  NUM_READ_PORTS  per-source valid (unused sources never cause hazards)
- dest_addr  in  ADDR_BITS  destination register
- dest_used  in  1  instruction writes dest_addr
- user_data_in  in  USER_WIDTH  control payload
- operand_data  out  NUM_READ_PORTS*DATA_WIDTH  registered operands
- dest_addr_out, dest_used_out  out  ADDR_BITS, 1  registered destination
- user_data_out  out  USER_WIDTH  registered payload
- rfetch_valid  out  1  output stage holds an instruction
- alu_ready  in  1  ALU consumes the output stage this cycle
- wr_enable  in  NUM_WRITE_PORTS  writeback strobes
- wr_addr  in  NUM_WRITE_PORTS*ADDR_BITS  writeback addresses
- wr_data  in  NUM_WRITE_PORTS*DATA_WIDTH  writeback data
- pending  out  NUM_REGISTERS  scoreboard bits (debug/forwarding hint)

## Operation
- Array write: every edge, each asserted wr_enable port writes its register. Same-address collision: highest-index port wins.
- Release: any write to register r clears pending[r], unless r is reserved in the same cycle. Set wins.
- Reserve: pending[dest_addr_out] set on handoff (rfetch_valid && alu_ready && dest_used_out && !flush).
- Hazard on source k (src_used[k]) when any of:
  - pending[src] is set and src is not written this cycle;
  - rfetch_valid && dest_used_out && dest_addr_out == src and the output stage is not handed off this cycle.
- Hazard on destination (dest_used): the same two tests applied to dest_addr (WAW).
- decode_ready = !reset && !flush && (!rfetch_valid || alu_ready) && no hazard.
- Accept (decode_valid && decode_ready): latch operands, dest, user data; rfetch_valid <= 1.
  - Operand k = same-cycle write data to that address if written (highest port wins), else array contents.
- Handoff without accept: rfetch_valid <= 0; operand/user/dest registers cleared to 0.
- Stall (rfetch_valid && !alu_ready): output stage holds all values.
- flush: rfetch_valid <= 0, stage registers cleared, no reservation made. Array writes and releases still occur. Existing pending bits kept, because older instructions still write back.
- Reset: array, pending, stage registers, rfetch_valid all 0 immediately (async).

## Timing
- Reset values: decode_ready 0 while reset is high, 1 after; all other outputs 0.
- Latency: accept at edge N → operands valid in the cycle after N, 1 cycle.
- Write at edge N → visible in the array to reads accepted at N+1. A read accepted at edge N sees it via bypass.
- Throughput: one instruction per cycle when alu_ready is held and there are no hazards.
- Dependent back-to-back pair (dest → src): second instruction stalls until writeback of the first. It is accepted in the writeback cycle via bypass. Minimum gap is the ALU writeback latency.
- decode_ready is combinational from src/dest inputs, pending, and alu_ready. Decode must hold its inputs while decode_valid && !decode_ready.

## Configuration
- W0RM_REGFILE_ZERO_REG_EN defined: register 0 always reads 0 and is never marked pending. Writes to it are discarded, including bypass. It never causes a hazard.
- Undefined: register 0 is an ordinary register.

## Test plan
- Reset mid-stall: rfetch_valid=1, pending=16'h0008, assert reset → all outputs and pending 0 in the same cycle, without waiting for a clock edge. Array reads 0 afterwards.
- Write collision: wr_enable=2'b11, both ports addr 5, data 0xAAAA/0x5555 → R5=0x5555. A read of R5 accepted in the same cycle returns 0x5555.
- RAW stall: issue dest=R3 and hand it off; pending[3]=1. Next src0=R3 → decode_ready=0 for 4 cycles. Writeback R3=0x1234 → accepted that cycle, operand0=0x1234, pending[3]=0.
- Set-beats-release: writeback to R7 on the same edge as handoff of a new dest=R7 → pending[7] stays 1.
- Flush: stage holds dest=R2, flush with alu_ready=1 → rfetch_valid=0 and pending[2] stays 0.
- Zero reg (macro on): write R0=0xFFFF_FFFF, then read R0 → 0. dest=R0 followed by src=R0 → no stall.
